// File: rtl/silife_spi_loader.sv
// SPI slave that exchanges silife grid rows with an external loader, one WIDTH-bit word per row.
// Optional readback of the previous row contents on MISO: SILIFE_LOADER_READBACK_EN.
module silife_spi_loader #(
  parameter int WIDTH       = 32,
  parameter int HEIGHT      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load_cs,
  input  logic                      i_load_clk,
  input  logic                      i_load_data,
  output logic                      o_load_data,
  output logic [$clog2(HEIGHT)-1:0] o_row_addr,
  output logic [WIDTH-1:0]          o_row_wdata,
  output logic                      o_row_we,
  input  logic [WIDTH-1:0]          i_row_rdata,
  output logic                      o_busy,
  output logic                      o_frame_done
);
  // state     | meaning
  // WAIT_IDLE | after reset, wait for CS high so no frame starts mid-transfer
  // IDLE      | CS high, waiting for CS falling edge
  // SHIFT     | frame active, shifting bits on SCK edges
  // COMMIT    | one cycle: full row written to the grid
  localparam int AW = $clog2(HEIGHT);
  localparam int BW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     row, row_n;
  logic [BW-1:0]     bitcnt, bitcnt_n;
  logic [WIDTH-1:0]  in_sr, in_sr_n;
  logic              done_n;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, din_sync;
  logic cs_hist, sck_hist;
  logic cs_s, sck_s, din_s;
  logic cs_rise, cs_fall, sck_rise, sck_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync  <= '0;
      sck_sync <= '0;
      din_sync <= '0;
      cs_hist  <= 1'b0;
      sck_hist <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_load_cs};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_load_clk};
      din_sync <= {din_sync[SYNC_STAGES-2:0], i_load_data};
      cs_hist  <= cs_sync[SYNC_STAGES-1];
      sck_hist <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign cs_rise  = cs_s & ~cs_hist;
  assign cs_fall  = ~cs_s & cs_hist;
  assign sck_rise = sck_s & ~sck_hist;
  assign sck_fall = ~sck_s & sck_hist;

`ifdef SILIFE_LOADER_READBACK_EN
  logic [WIDTH-1:0] out_sr, out_sr_n;
  logic             load_pend, load_n;
`endif

  always_comb begin
    state_n  = state;
    row_n    = row;
    bitcnt_n = bitcnt;
    in_sr_n  = in_sr;
    done_n   = 1'b0;
`ifdef SILIFE_LOADER_READBACK_EN
    out_sr_n = out_sr;
    load_n   = load_pend;
`endif
    case (state)
      WAIT_IDLE: if (cs_s) state_n = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_n  = SHIFT;
          row_n    = '0;
          bitcnt_n = '0;
`ifdef SILIFE_LOADER_READBACK_EN
          load_n   = 1'b1;
`endif
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n  = IDLE;
          bitcnt_n = '0;
`ifdef SILIFE_LOADER_READBACK_EN
          load_n   = 1'b0;
`endif
        end else begin
          // Grid read data follows o_row_addr, so the new row is captured one cycle after the address moves.
          // The falling edge right after a commit must not shift the freshly loaded word.
`ifdef SILIFE_LOADER_READBACK_EN
          if (load_pend) begin
            out_sr_n = i_row_rdata;
            load_n   = 1'b0;
          end else if (sck_fall && bitcnt != '0) begin
            out_sr_n = {out_sr[WIDTH-2:0], 1'b0};
          end
`endif
          if (sck_rise) begin
            in_sr_n  = {in_sr[WIDTH-2:0], din_s};
            bitcnt_n = bitcnt + 1'b1;
            if (bitcnt_n == BW'(WIDTH)) state_n = COMMIT;
          end
        end
      end
      COMMIT: begin
        bitcnt_n = '0;
        if (row == AW'(HEIGHT - 1)) begin
          row_n  = '0;
          done_n = 1'b1;
        end else begin
          row_n = row + 1'b1;
        end
        state_n = cs_rise ? IDLE : SHIFT;
`ifdef SILIFE_LOADER_READBACK_EN
        load_n  = ~cs_rise;
`endif
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_IDLE;
      row          <= '0;
      bitcnt       <= '0;
      in_sr        <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state        <= state_n;
      row          <= row_n;
      bitcnt       <= bitcnt_n;
      in_sr        <= in_sr_n;
      o_frame_done <= done_n;
    end
  end

`ifdef SILIFE_LOADER_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      out_sr      <= '0;
      load_pend   <= 1'b0;
      o_load_data <= 1'b0;
    end else begin
      out_sr      <= out_sr_n;
      load_pend   <= load_n;
      o_load_data <= (state_n == SHIFT || state_n == COMMIT) ? out_sr_n[WIDTH-1] : 1'b0;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^i_row_rdata;
  assign o_load_data  = 1'b0;
`endif

  assign o_row_addr  = row;
  assign o_row_wdata = in_sr;
  assign o_row_we    = (state == COMMIT) && !reset;
  assign o_busy      = (state == SHIFT) || (state == COMMIT);

endmodule

// File: tb/tb_silife_spi_loader.sv
// Self-checking bench for silife_spi_loader: randomized row exchanges against a frame-level grid model.
module tb_silife_spi_loader;
  localparam int W = 32;
  localparam int H = 32;
  localparam int AW = $clog2(H);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cs = 1'b1, sck = 1'b0, din = 1'b0;
  logic miso, row_we, busy, frame_done;
  logic [AW-1:0] row_addr;
  logic [W-1:0] row_wdata, row_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] mem [H];
  logic [W-1:0] ref_g [H];
  logic [W-1:0] tx [$];
  int wa [$];
  logic [W-1:0] wd [$];
  int wc [$];
  int dc [$];

  silife_spi_loader #(.WIDTH(W), .HEIGHT(H), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .i_load_cs(cs), .i_load_clk(sck), .i_load_data(din),
    .o_load_data(miso), .o_row_addr(row_addr), .o_row_wdata(row_wdata),
    .o_row_we(row_we), .i_row_rdata(row_rdata), .o_busy(busy),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign row_rdata = mem[row_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (row_we) mem[row_addr] <= row_wdata;
  end

  always @(negedge clk) begin
    if (row_we) begin
      wa.push_back(int'(row_addr));
      wd.push_back(row_wdata);
      wc.push_back(cyc);
    end
    if (frame_done) dc.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  // One word MSB first, SCK mode 0; MISO captured just before each rising edge.
  task automatic send_word(input logic [W-1:0] w, input int nbits, output logic [W-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      din = w[W-1-i];
      ticks(8);
      got[W-1-i] = miso;
      sck = 1'b1;
      ticks(8);
      sck = 1'b0;
    end
    ticks(8);
  endtask

  // Sends tx[0..nrows-1] as full rows, then optionally a truncated row, and checks the result.
  task automatic run_frame(input string tag, input int nrows, input int tail_bits);
    logic [W-1:0] got, exp_dout;
    int exp_done [$];
    int n;
    clear_log();
    cs = 1'b0;
    ticks(10);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    for (int r = 0; r < nrows; r++) begin
      send_word(tx[r], W, got);
`ifdef SILIFE_LOADER_READBACK_EN
      exp_dout = ref_g[r % H];
`else
      exp_dout = '0;
`endif
      chk($sformatf("%s.dout%0d", tag, r), 64'(got), 64'(exp_dout));
      ref_g[r % H] = tx[r];
    end
    if (tail_bits > 0) send_word(tx[nrows], tail_bits, got);
    ticks(4);
    cs = 1'b1;
    ticks(10);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk({tag, ".idle_miso"}, 64'(miso), 64'd0);
    chk({tag, ".nwr"}, 64'(wa.size()), 64'(nrows));
    n = (wa.size() < nrows) ? wa.size() : nrows;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.addr%0d", tag, i), 64'(wa[i]), 64'(i % H));
      chk($sformatf("%s.data%0d", tag, i), 64'(wd[i]), 64'(tx[i]));
      if (i % H == H - 1) exp_done.push_back(wc[i] + 1);
    end
    chk({tag, ".ndone"}, 64'(dc.size()), 64'(nrows / H));
    for (int i = 0; i < exp_done.size() && i < dc.size(); i++)
      chk($sformatf("%s.done_cyc%0d", tag, i), 64'(dc[i]), 64'(exp_done[i]));
  endtask

  task automatic rand_rows(input int n);
    tx.delete();
    for (int i = 0; i < n; i++) tx.push_back(W'($urandom()));
  endtask

  initial begin
    logic [W-1:0] got;
    for (int i = 0; i < H; i++) begin
      mem[i] = W'($urandom());
      ref_g[i] = mem[i];
    end
    ticks(3);
    reset = 1'b0;
    #1;
    chk("rst.we", 64'(row_we), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.miso", 64'(miso), 64'd0);
    chk("rst.done", 64'(frame_done), 64'd0);
    chk("rst.addr", 64'(row_addr), 64'd0);
    ticks(10);

    tx.delete();
    tx.push_back(32'hA500_0001);
    run_frame("t1", 1, 0);

    mem[0] = 32'hDEAD_BEEF; ref_g[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h1234_5678; ref_g[1] = 32'h1234_5678;
    rand_rows(2);
    run_frame("t2", 2, 0);

    tx.delete();
    for (int i = 0; i < H; i++) tx.push_back(W'(1) << i);
    run_frame("t3", H, 0);

    rand_rows(H + 1);
    run_frame("t4", H + 1, 0);

    rand_rows(4);
    run_frame("t5a", 3, 17);
    rand_rows(1);
    run_frame("t5b", 1, 0);

    clear_log();
    cs = 1'b0;
    ticks(10);
    send_word(W'($urandom()), 10, got);
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    ticks(10);
    chk("t6.rst_nwr", 64'(wa.size()), 64'd0);
    chk("t6.rst_busy", 64'(busy), 64'd0);
    send_word(W'($urandom()), W, got);
    ticks(10);
    chk("t6.wait_nwr", 64'(wa.size()), 64'd0);
    chk("t6.wait_busy", 64'(busy), 64'd0);
    chk("t6.wait_miso", 64'(got), 64'd0);
    cs = 1'b1;
    ticks(10);
    rand_rows(2);
    run_frame("t6", 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
